cma_job_sched: RTL

CMA_JOB_SCHED -- requirements
Module: cma_job_sched

---
 rtl/cma_sched_pkg.sv | 36 +++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/cma_job_sched.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cma_sched_pkg.sv
// Shared types for the CMA job scheduler: FSM states, the latched job
// descriptor and the layout of the configuration beat.
package cma_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CFG    = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    // Descriptor fields are sized for the widest supported instance.
    localparam int JOB_AW  = 16;
    localparam int JOB_IDW = 3;

    typedef struct packed {
        logic [3:0]         mode;
        logic [3:0]         fw;
        logic [JOB_AW-1:0]  base;
        logic [JOB_AW-1:0]  len;
        logic [JOB_IDW-1:0] id;
    } job_t;

    localparam int CFG_MODE_LSB = 0;
    localparam int CFG_FW_LSB   = 4;
    localparam int MODE_MAC_BIT = 2;

    function automatic logic [31:0] cfg_beat(input logic [3:0] mode, input logic [3:0] fw);
        logic [31:0] beat;
        beat = '0;
        beat[CFG_MODE_LSB +: 4] = mode;
        beat[CFG_FW_LSB +: 4]   = fw;
        return beat;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from the index after the
// last accepted grant; the pointer moves only when advance is high.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] idx;
    int            sum;

    // Walk offsets from far to near so the nearest requester wins.
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        idx   = '0;
        sum   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            sum = int'(ptr_q) + i;
            if (sum >= N) begin
                sum = sum - N;
            end
            idx = PW'(sum);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                ptr_d      = (sum == N - 1) ? '0 : PW'(sum + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (advance && (|req)) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cma_job_sched.sv
// Job scheduler feeding a complex multiplier-accumulator: arbitrates requesters,
// sends a config beat, streams operand pairs from memory and returns results.
module cma_job_sched
    import cma_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*4-1:0]        req_mode,
    input  logic [NREQ*4-1:0]        req_fw,
    input  logic [NREQ*AW-1:0]       req_base,
    input  logic [NREQ*AW-1:0]       req_len,
    output logic                     mem_rd,
    output logic [AW-1:0]            mem_addr,
    input  logic [31:0]              mem_rdata,
    output logic                     cma_tvalid,
    output logic                     cma_tlast,
    output logic [31:0]              cma_tdata,
    input  logic [31:0]              cma_rdata,
    output logic                     res_valid,
    output logic [$clog2(NREQ)-1:0]  res_id,
    output logic [31:0]              res_data,
    output logic                     res_last,
    output logic                     busy
);
    localparam int IW = $clog2(NREQ);

    logic [3:0]    mode_a [NREQ];
    logic [3:0]    fw_a   [NREQ];
    logic [AW-1:0] base_a [NREQ];
    logic [AW-1:0] len_a  [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign mode_a[gi] = req_mode[gi*4 +: 4];
        assign fw_a[gi]   = req_fw[gi*4 +: 4];
        assign base_a[gi] = req_base[gi*AW +: AW];
        assign len_a[gi]  = req_len[gi*AW +: AW];
    end

    state_e        state_q, state_d;
    job_t          job_q, job_d, sel_job;
    logic [AW:0]   cnt_q, cnt_d, cnt_inc, total;
    logic          drain_q, drain_d;
    logic [NREQ-1:0] grant;
    logic          advance;
    logic [AW-1:0] base, len;
    logic          mac;
    logic          unused_job;

    assign advance    = (state_q == IDLE) && (|req_valid);
    assign base       = job_q.base[AW-1:0];
    assign len        = job_q.len[AW-1:0];
    assign total      = {len, 1'b0};
    assign cnt_inc    = cnt_q + 1'b1;
    assign mac        = job_q.mode[MODE_MAC_BIT];
    assign busy       = (state_q != IDLE);
    assign unused_job = ^{job_q.base, job_q.len, job_q.id};

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (advance),
        .grant   (grant)
    );

    always_comb begin
        sel_job = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_job.mode = mode_a[i];
                sel_job.fw   = fw_a[i];
                sel_job.base = JOB_AW'(base_a[i]);
                sel_job.len  = JOB_AW'(len_a[i]);
                sel_job.id   = JOB_IDW'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        job_d      = job_q;
        cnt_d      = cnt_q;
        drain_d    = drain_q;
        req_ready  = '0;
        mem_rd     = 1'b0;
        mem_addr   = '0;
        cma_tvalid = 1'b0;
        cma_tlast  = 1'b0;
        cma_tdata  = '0;
        res_valid  = 1'b0;
        res_last   = 1'b0;
        case (state_q)
            IDLE: begin
                if ((|req_valid) && !rst) begin
                    req_ready = grant;
                    job_d     = sel_job;
                    state_d   = CFG;
                end
            end
            CFG: begin
                cma_tvalid = 1'b1;
                cma_tlast  = 1'b1;
                cma_tdata  = cfg_beat(job_q.mode, job_q.fw);
                cnt_d      = '0;
                drain_d    = 1'b0;
                if (len != '0) begin
                    mem_rd   = 1'b1;
                    mem_addr = base;
                    state_d  = STREAM;
                end else begin
                    state_d  = DRAIN;
                end
            end
            STREAM: begin
                cma_tvalid = 1'b1;
                cma_tdata  = mem_rdata;
                // Prefetch the operand for the next beat, never past the last one.
                if (cnt_inc < total) begin
                    mem_rd   = 1'b1;
                    mem_addr = base + cnt_inc[AW-1:0];
                end
                // Plain multiply: a result follows each b beat (odd index).
                if (!mac && !cnt_q[0] && (cnt_q != '0)) begin
                    res_valid = 1'b1;
                end
                cnt_d = cnt_inc;
                if (cnt_inc == total) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_q || (!mac && (len != '0))) begin
                    res_valid = 1'b1;
                    res_last  = 1'b1;
                    state_d   = IDLE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign res_data = res_valid ? cma_rdata : '0;
    assign res_id   = res_valid ? job_q.id[IW-1:0] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            job_q   <= '0;
            cnt_q   <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            job_q   <= job_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
        end
    end

endmodule
